// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the memory responder: access-size encodings,
// responder FSM states and the size/alignment rule.
package mem_responder_pkg;

  localparam logic [1:0] MEM_OP_BYTE    = 2'b00;
  localparam logic [1:0] MEM_OP_HALF    = 2'b01;
  localparam logic [1:0] MEM_OP_WORD    = 2'b10;
  localparam logic [1:0] MEM_OP_INVALID = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } resp_state_t;

  function automatic logic mem_misaligned(input logic [1:0] op, input logic [1:0] addr_lo);
    case (op)
      MEM_OP_HALF: return addr_lo[0];
      MEM_OP_WORD: return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake between the memory access unit (master) and a
// memory target (slave).
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_write;
  logic        req_is_unsigned;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_op_fault;
  logic        rsp_addr_fault;
  logic        rsp_access_fault;

  modport master (
    output req_valid, req_is_write, req_is_unsigned, req_op, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_op_fault, rsp_addr_fault, rsp_access_fault
  );

  modport slave (
    input  req_valid, req_is_write, req_is_unsigned, req_op, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_op_fault, rsp_addr_fault, rsp_access_fault
  );
endinterface

// File: rtl/mem_responder_lane_align.sv
// Combinational byte-lane steering: store byte enables / replicated data and
// load lane extraction with zero or sign extension.
module mem_responder_lane_align
  import mem_responder_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    be          = '0;
    wdata_lanes = '0;
    case (op)
      MEM_OP_BYTE: begin
        be          = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
      end
      MEM_OP_HALF: begin
        be          = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
      end
      MEM_OP_WORD: begin
        be          = '1;
        wdata_lanes = wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    rbyte = '0;
    case (addr_lo)
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];
  end

  always_comb begin
    rdata_ext = '0;
    case (op)
      MEM_OP_BYTE: rdata_ext = {{24{~is_unsigned & rbyte[7]}}, rbyte};
      MEM_OP_HALF: rdata_ext = {{16{~is_unsigned & rhalf[15]}}, rhalf};
      MEM_OP_WORD: rdata_ext = rword;
      default:     rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Memory target: accepts one load/store at a time, services it against an
// internal word RAM after LATENCY wait cycles and returns data plus fault flags.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  mem_responder_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) * 33'd4;

  resp_state_t state;
  logic [3:0]  cnt;
  logic        wr_q, uns_q;
  logic [1:0]  op_q;
  logic [31:0] addr_q, wdata_q;

  logic [31:0] ram [DEPTH_WORDS];

  logic [31:0]      off;
  logic [IDX_W-1:0] idx;
  logic             op_f, addr_f, acc_f, any_f;
  logic             resp_entry, commit;
  logic [3:0]       be;
  logic [31:0]      wlanes, rword, rext;

  assign off        = addr_q - BASE_ADDR;
  assign idx        = off[IDX_W+1:2];
  assign op_f       = op_q == MEM_OP_INVALID;
  assign addr_f     = mem_misaligned(op_q, addr_q[1:0]);
  assign acc_f      = {1'b0, off} >= SPAN;
  assign any_f      = op_f | addr_f | acc_f;
  assign rword      = ram[idx];
  assign resp_entry = (state == WAIT) && (cnt == '0);
  assign commit     = resp_entry && wr_q && !any_f;

  mem_responder_lane_align u_align (
    .op          (op_q),
    .addr_lo     (addr_q[1:0]),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rword       (rword),
    .be          (be),
    .wdata_lanes (wlanes),
    .rdata_ext   (rext)
  );

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) ram[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  // WAIT is always entered with the counter at LATENCY, so the registered
  // request gets one cycle before the count; this gives accept-to-valid of LATENCY+1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= IDLE;
      cnt                  <= '0;
      wr_q                 <= 1'b0;
      uns_q                <= 1'b0;
      op_q                 <= '0;
      addr_q               <= '0;
      wdata_q              <= '0;
      bus.req_ready        <= 1'b1;
      bus.rsp_valid        <= 1'b0;
      bus.rsp_rdata        <= '0;
      bus.rsp_op_fault     <= 1'b0;
      bus.rsp_addr_fault   <= 1'b0;
      bus.rsp_access_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            wr_q          <= bus.req_is_write;
            uns_q         <= bus.req_is_unsigned;
            op_q          <= bus.req_op;
            addr_q        <= bus.req_addr;
            wdata_q       <= bus.req_wdata;
            cnt           <= 4'(LATENCY);
            bus.req_ready <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            bus.rsp_valid        <= 1'b1;
            bus.rsp_op_fault     <= op_f;
            bus.rsp_addr_fault   <= addr_f;
            bus.rsp_access_fault <= acc_f;
            bus.rsp_rdata        <= (any_f || wr_q) ? '0 : rext;
            state                <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid        <= 1'b0;
            bus.rsp_rdata        <= '0;
            bus.rsp_op_fault     <= 1'b0;
            bus.rsp_addr_fault   <= 1'b0;
            bus.rsp_access_fault <= 1'b0;
            bus.req_ready        <= 1'b1;
            state                <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomised and directed checks of mem_responder against a byte-array model.
module tb_mem_responder;

  localparam int unsigned LAT = 2;
  localparam int unsigned EXP_LAT = LAT + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  logic [7:0] mm [4096];

  mem_responder_if bus ();

  mem_responder #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (32'h0000_0000),
    .LATENCY     (LAT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic model_step(input logic wr, input logic uns, input logic [1:0] op,
                            input logic [31:0] addr, input logic [31:0] wd,
                            output logic [31:0] erd, output logic [2:0] eflt);
    logic opf, af, acc;
    int unsigned a;
    opf  = (op == 2'd3);
    af   = (op == 2'd1 && addr % 2 != 0) || (op == 2'd2 && addr % 4 != 0);
    acc  = (addr >= 32'd4096);
    eflt = {opf, af, acc};
    erd  = '0;
    a    = addr;
    if (eflt == 3'b000) begin
      if (wr) begin
        mm[a] = wd[7:0];
        if (op >= 2'd1) mm[a+1] = wd[15:8];
        if (op == 2'd2) begin
          mm[a+2] = wd[23:16];
          mm[a+3] = wd[31:24];
        end
      end else begin
        case (op)
          2'd0: erd = uns ? 32'(mm[a]) : 32'($signed(mm[a]));
          2'd1: erd = uns ? 32'({mm[a+1], mm[a]}) : 32'($signed({mm[a+1], mm[a]}));
          default: erd = {mm[a+3], mm[a+2], mm[a+1], mm[a]};
        endcase
      end
    end
  endtask

  task automatic do_req(input logic wr, input logic uns, input logic [1:0] op,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic [2:0] flt, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.req_valid       = 1'b1;
    bus.req_is_write    = wr;
    bus.req_is_unsigned = uns;
    bus.req_op          = op;
    bus.req_addr        = addr;
    bus.req_wdata       = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd  = bus.rsp_rdata;
    flt = {bus.rsp_op_fault, bus.rsp_addr_fault, bus.rsp_access_fault};
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_total++;
    if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready);
    else n_pass++;
    n_total++;
    if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid);
    else n_pass++;
    n_total++;
    if (bus.rsp_rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", bus.rsp_rdata);
    else n_pass++;
    n_total++;
    if ({bus.rsp_op_fault, bus.rsp_addr_fault, bus.rsp_access_fault} !== 3'b000)
      $display("FAIL reset_faults got=%b exp=000",
               {bus.rsp_op_fault, bus.rsp_addr_fault, bus.rsp_access_fault});
    else n_pass++;
  endtask

  task automatic test_load_store();
    logic [31:0] rd, erd;
    logic [2:0]  flt, eflt;
    int          lat;
    logic [31:0] exp_rd [6] = '{32'h0, 32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0};
    logic        wr_v  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        uns_v [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  op_v  [6] = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0};
    logic [31:0] ad_v  [6] = '{32'h10, 32'h10, 32'h13, 32'h13, 32'h10, 32'h11};
    logic [31:0] wd_v  [6] = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000005A};
    for (int i = 0; i < 6; i++) begin
      do_req(wr_v[i], uns_v[i], op_v[i], ad_v[i], wd_v[i], rd, flt, lat);
      model_step(wr_v[i], uns_v[i], op_v[i], ad_v[i], wd_v[i], erd, eflt);
      n_total++;
      if (rd !== exp_rd[i] || flt !== 3'b000)
        $display("FAIL ls_%0d got rd=%h flt=%b exp rd=%h flt=000", i, rd, flt, exp_rd[i]);
      else n_pass++;
      n_total++;
      if (lat != EXP_LAT) $display("FAIL ls_latency_%0d got=%0d exp=%0d", i, lat, EXP_LAT);
      else n_pass++;
    end
    do_req(1'b0, 1'b0, 2'd2, 32'h10, 32'h0, rd, flt, lat);
    n_total++;
    if (rd !== 32'hDEAD5AEF) $display("FAIL byte_merge got=%h exp=deadbeef->dead5aef", rd);
    else n_pass++;
  endtask

  task automatic test_faults();
    logic [31:0] rd, erd;
    logic [2:0]  flt, eflt;
    int          lat;
    do_req(1'b1, 1'b0, 2'd2, 32'h20, 32'hCAFEF00D, rd, flt, lat);
    model_step(1'b1, 1'b0, 2'd2, 32'h20, 32'hCAFEF00D, erd, eflt);
    do_req(1'b0, 1'b0, 2'd3, 32'h20, 32'h0, rd, flt, lat);
    n_total++;
    if (flt !== 3'b100 || rd !== 32'h0) $display("FAIL op_fault got flt=%b rd=%h exp flt=100 rd=0", flt, rd);
    else n_pass++;
    do_req(1'b0, 1'b0, 2'd1, 32'h21, 32'h0, rd, flt, lat);
    n_total++;
    if (flt !== 3'b010 || rd !== 32'h0) $display("FAIL half_misalign got flt=%b rd=%h exp flt=010 rd=0", flt, rd);
    else n_pass++;
    do_req(1'b1, 1'b0, 2'd2, 32'h22, 32'h12345678, rd, flt, lat);
    n_total++;
    if (flt !== 3'b010) $display("FAIL word_store_misalign got flt=%b exp=010", flt);
    else n_pass++;
    do_req(1'b0, 1'b0, 2'd2, 32'h20, 32'h0, rd, flt, lat);
    n_total++;
    if (rd !== 32'hCAFEF00D) $display("FAIL faulted_store_no_write got=%h exp=cafef00d", rd);
    else n_pass++;
    do_req(1'b0, 1'b0, 2'd2, 32'h1000, 32'h0, rd, flt, lat);
    n_total++;
    if (flt !== 3'b001 || rd !== 32'h0) $display("FAIL access_end got flt=%b rd=%h exp flt=001 rd=0", flt, rd);
    else n_pass++;
    do_req(1'b0, 1'b0, 2'd2, 32'h1003, 32'h0, rd, flt, lat);
    n_total++;
    if (flt !== 3'b011) $display("FAIL addr_and_access got flt=%b exp=011", flt);
    else n_pass++;
    do_req(1'b0, 1'b1, 2'd0, 32'hFFFF_FFFC, 32'h0, rd, flt, lat);
    n_total++;
    if (flt !== 3'b001) $display("FAIL access_wrap got flt=%b exp=001", flt);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] rd0;
    logic [31:0] rd;
    logic [2:0]  flt;
    int          lat;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_is_write = 1'b0;
    bus.req_op       = 2'd2;
    bus.req_addr     = 32'h10;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd0 = bus.rsp_rdata;
    n_total++;
    if (rd0 !== 32'hDEAD5AEF) $display("FAIL bp_data got=%h exp=dead5aef", rd0);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      bus.req_valid    = 1'b1;
      bus.req_is_write = 1'b1;
      bus.req_addr     = 32'h10;
      bus.req_wdata    = $urandom;
      @(posedge clk);
      #1;
      n_total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== rd0 || bus.req_ready !== 1'b0)
        $display("FAIL bp_hold_%0d got v=%b rd=%h rr=%b exp v=1 rd=%h rr=0",
                 i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, rd0);
      else n_pass++;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    n_total++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL bp_release got v=%b rr=%b exp v=0 rr=1", bus.rsp_valid, bus.req_ready);
    else n_pass++;
    // rsp_ready held high from before the request: must not shorten the wait
    bus.rsp_ready = 1'b1;
    do_req(1'b0, 1'b0, 2'd2, 32'h10, 32'h0, rd, flt, lat);
    n_total++;
    if (rd !== 32'hDEAD5AEF || lat != EXP_LAT)
      $display("FAIL early_ready got rd=%h lat=%0d exp rd=dead5aef lat=%0d", rd, lat, EXP_LAT);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd;
    logic [2:0]  flt, eflt;
    int          lat;
    do_req(1'b1, 1'b0, 2'd2, 32'h30, 32'h22222222, rd, flt, lat);
    model_step(1'b1, 1'b0, 2'd2, 32'h30, 32'h22222222, erd, eflt);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_is_write = 1'b1;
    bus.req_op       = 2'd2;
    bus.req_addr     = 32'h30;
    bus.req_wdata    = 32'h11111111;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    n_total++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0)
      $display("FAIL reset_abort got rr=%b v=%b exp rr=1 v=0", bus.req_ready, bus.rsp_valid);
    else n_pass++;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    do_req(1'b0, 1'b0, 2'd2, 32'h30, 32'h0, rd, flt, lat);
    n_total++;
    if (rd !== 32'h22222222) $display("FAIL reset_no_commit got=%h exp=22222222", rd);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, addr, wd;
    logic [2:0]  flt, eflt;
    logic [1:0]  op;
    logic        wr, uns;
    int          lat;
    int unsigned kind;
    for (int unsigned a = 32'h40; a < 32'hC0; a += 4) begin
      wd = $urandom;
      do_req(1'b1, 1'b0, 2'd2, a, wd, rd, flt, lat);
      model_step(1'b1, 1'b0, 2'd2, a, wd, erd, eflt);
    end
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      wr   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      op   = 2'($urandom_range(0, 2));
      wd   = $urandom;
      addr = 32'h40 + $urandom_range(0, 127);
      if (kind == 7) addr = 32'h1000 + $urandom_range(0, 255);
      if (kind == 8) addr = 32'hFFFF_FF00 + $urandom_range(0, 255);
      if (kind == 9) op = 2'd3;
      do_req(wr, uns, op, addr, wd, rd, flt, lat);
      model_step(wr, uns, op, addr, wd, erd, eflt);
      n_total++;
      if (rd !== erd || flt !== eflt || lat != EXP_LAT)
        $display("FAIL rand_%0d wr=%b op=%0d addr=%h got rd=%h flt=%b lat=%0d exp rd=%h flt=%b lat=%0d",
                 i, wr, op, addr, rd, flt, lat, erd, eflt, EXP_LAT);
      else n_pass++;
    end
  endtask

  initial begin
    bus.req_valid       = 1'b0;
    bus.req_is_write    = 1'b0;
    bus.req_is_unsigned = 1'b0;
    bus.req_op          = 2'd0;
    bus.req_addr        = '0;
    bus.req_wdata       = '0;
    bus.rsp_ready       = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    test_load_store();
    test_faults();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
